y_update_sequencer: RTL and testbench
=====================================

Name: y_update_sequencer

Overview:
- Top-level scheduler for the Y-update loop.
- Alternately enables the updateY compute control path and the write-Y module, and counts iterations.
- Stops on an iteration limit or an external convergence flag.
- Detects protocol violations (stray or simultaneous done flags) and hung phases (watchdog), then parks in a sticky error state.

Parameters:
- NUM_ITER, 8, maximum compute+write iterations per run (1..2^ITER_W-1)
- ITER_W, 8, width of the iteration counter
- TIMEOUT_CYC, 1024, maximum cycles a phase may stay enabled without its done flag
- TMO_W, 11, watchdog counter width (must hold TIMEOUT_CYC)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_start  in  1  begin a run; sampled only in IDLE
- in_abort  in  1  return to IDLE from any busy state
- in_clearErr  in  1  leave ERROR to IDLE
- in_converged  in  1  convergence indication; sampled in CHECK
- in_updateYCtrlPathDoneFlag  in  1  compute phase complete (pulse or level)
- in_updateYwriteDoneFlag  in  1  Y SRAM write phase complete (pulse or level)
- op_updateYmoduleEnable  out  1  enable for the compute module
- op_writeYvalEnable  out  1  enable for the write module
- op_busy  out  1  high in UPDATE/WRITE/CHECK
- op_allDone  out  1  one-cycle pulse at run completion
- op_iterCount  out  ITER_W  completed iterations in the current or last run
- op_error  out  1  sticky error flag
- op_errorCode  out  2  01 stray done, 10 simultaneous dones, 11 timeout

Behaviour:
- Reset: asynchronous, active-low; all outputs are registered.
  - While reset is low: state=IDLE, all outputs 0, op_iterCount=0, watchdog=0.
- States: IDLE, UPDATE, WRITE, CHECK, DONE, ERROR. Each enable is 1 only in its own state (UPDATE or WRITE). The two enables are never high together.
- IDLE:
  - in_start=1 at edge t: op_iterCount clears and state=UPDATE at t+1.
  - Latency start→enable is 1 cycle.
- UPDATE:
  - in_updateYCtrlPathDoneFlag=1: next state WRITE. op_updateYmoduleEnable falls and op_writeYvalEnable rises on the same edge.
- WRITE:
  - in_updateYwriteDoneFlag=1: next state CHECK, and op_iterCount increments on that edge.
- CHECK (1 cycle, both enables 0):
  - If op_iterCount==NUM_ITER or in_converged=1: next state DONE.
  - Otherwise: next state UPDATE.
- DONE: op_allDone=1 for exactly one cycle, then IDLE. op_iterCount holds until the next start.
- Stray done (error code 01):
  - In UPDATE: in_updateYwriteDoneFlag alone.
  - In WRITE: in_updateYCtrlPathDoneFlag alone.
  - Either done in CHECK.
  - Action: ERROR, code 01.
  - Done flags in IDLE, DONE or ERROR are ignored.
- Both done flags high in UPDATE/WRITE/CHECK: ERROR, code 10. This takes priority over code 01 and over normal transitions.
- Watchdog:
  - Clears on every state change; counts while in UPDATE or WRITE.
  - Reaching TIMEOUT_CYC-1 with no done flag: ERROR, code 11 on the next edge.
- ERROR:
  - Enables 0, op_error=1, code held.
  - in_clearErr: IDLE next cycle, op_error and code cleared.
  - in_start is ignored while in ERROR.
- in_abort:
  - From UPDATE/WRITE/CHECK: IDLE next cycle, enables drop, no op_allDone, op_iterCount holds.
  - Priority: abort > error detection > normal transition.
- Reset asserted mid-run: immediate return to IDLE values; no completion pulse.
- Level-held done flags are consumed once: a flag held high after WRITE→CHECK counts as stray, so sources must pulse or drop the flag when disabled.

Decomposition:
- Shared package (y_update_pkg):
  - State enum.
  - Error-code constants ERR_NONE=00, ERR_STRAY=01, ERR_BOTH=10, ERR_TMO=11.
- One natural sub-module, y_phase_watchdog: clear/count/expire counter parameterised by TIMEOUT_CYC. Everything else stays in the sequencer.

Test Plan:
- Normal run (NUM_ITER=3, converged=0): start, each done pulsed 4 cycles after its enable rises.
  - Three UPDATE/WRITE alternations, op_iterCount ends at 3.
  - op_allDone pulses once.
  - Enables never overlap.
- Convergence: in_converged=1 during the CHECK of iteration 2 → DONE with op_iterCount=2, one op_allDone pulse.
- Simultaneous dones: both flags high in UPDATE → next cycle op_error=1, code 10, enables 0.
  - in_clearErr → IDLE, op_error=0.
- Stray done: write-done pulse during UPDATE → code 01.
- Timeout (TIMEOUT_CYC=16): no done in WRITE → op_error=1, code 11 exactly 16 cycles after op_writeYvalEnable rose.
- Abort and reset mid-run:
  - in_abort in WRITE of iteration 2 → IDLE next cycle, op_iterCount=1, no op_allDone.
  - reset low mid-UPDATE → all outputs 0 with no clock edge.

Source files
------------

// File: rtl/y_update_pkg.sv
// Shared definitions for the Y-update loop sequencer.
//   seq_state_e : sequencer FSM states
//   ERR_*       : values reported on op_errorCode
//   is_busy()   : true for the states that make up an active run
package y_update_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StUpdate,
    StWrite,
    StCheck,
    StDone,
    StError
  } seq_state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_STRAY = 2'b01;
  localparam logic [1:0] ERR_BOTH  = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  function automatic logic is_busy(input seq_state_e s);
    return (s == StUpdate) || (s == StWrite) || (s == StCheck);
  endfunction

endpackage

// File: rtl/y_update_sequencer_if.sv
// Control/status bundle between the Y-update sequencer and its surroundings.
//   in_*  : run control and phase done flags, driven by the environment
//   op_*  : phase enables and run status, driven by the sequencer
// Modports:
//   master : the sequencer side
//   slave  : the environment side (compute/write modules, host)
interface y_update_sequencer_if #(
  parameter int unsigned ITER_W = 8
);

  logic              in_start;
  logic              in_abort;
  logic              in_clearErr;
  logic              in_converged;
  logic              in_updateYCtrlPathDoneFlag;
  logic              in_updateYwriteDoneFlag;

  logic              op_updateYmoduleEnable;
  logic              op_writeYvalEnable;
  logic              op_busy;
  logic              op_allDone;
  logic [ITER_W-1:0] op_iterCount;
  logic              op_error;
  logic [1:0]        op_errorCode;

  modport master (
    input  in_start,
    input  in_abort,
    input  in_clearErr,
    input  in_converged,
    input  in_updateYCtrlPathDoneFlag,
    input  in_updateYwriteDoneFlag,
    output op_updateYmoduleEnable,
    output op_writeYvalEnable,
    output op_busy,
    output op_allDone,
    output op_iterCount,
    output op_error,
    output op_errorCode
  );

  modport slave (
    output in_start,
    output in_abort,
    output in_clearErr,
    output in_converged,
    output in_updateYCtrlPathDoneFlag,
    output in_updateYwriteDoneFlag,
    input  op_updateYmoduleEnable,
    input  op_writeYvalEnable,
    input  op_busy,
    input  op_allDone,
    input  op_iterCount,
    input  op_error,
    input  op_errorCode
  );

endinterface

// File: rtl/y_phase_watchdog.sv
// Phase watchdog: counts cycles spent in one enabled phase.
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   clear_i   : restart the count (a state change is happening)
//   count_i   : advance the count this cycle
//   expired_o : count has reached TIMEOUT_CYC-1
// The counter saturates at its limit so it can never wrap back to a safe value.
module y_phase_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned TMO_W       = 11
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [TMO_W-1:0] Limit = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != Limit)) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == Limit);

endmodule

// File: rtl/y_update_sequencer.sv
// Top-level scheduler for the Y-update loop.
// Alternates the compute phase (UPDATE) and the Y SRAM write phase (WRITE),
// counts completed iterations and stops on NUM_ITER or on convergence. Stray or
// simultaneous done flags and hung phases park the FSM in a sticky ERROR state.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : control/status bundle (master side); all op_* outputs registered
module y_update_sequencer
  import y_update_pkg::*;
#(
  parameter int unsigned NUM_ITER    = 8,
  parameter int unsigned ITER_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned TMO_W       = 11
) (
  input  logic                 clock,
  input  logic                 reset,
  y_update_sequencer_if.master bus
);

  seq_state_e        state_d, state_q;
  logic [ITER_W-1:0] iter_d, iter_q;
  logic [1:0]        err_code_d, err_code_q;
  logic              upd_en_q, wr_en_q, busy_q, all_done_q, error_q;

  logic upd_done, wr_done;
  logic wdg_clear, wdg_count, wdg_expired;

  assign upd_done = bus.in_updateYCtrlPathDoneFlag;
  assign wr_done  = bus.in_updateYwriteDoneFlag;

  // Any state change restarts the watchdog; it only runs while a phase is enabled.
  assign wdg_clear = (state_d != state_q);
  assign wdg_count = (state_q == StUpdate) || (state_q == StWrite);

  y_phase_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMO_W       (TMO_W)
  ) u_watchdog (
    .clk_i     (clock),
    .rst_ni    (reset),
    .clear_i   (wdg_clear),
    .count_i   (wdg_count),
    .expired_o (wdg_expired)
  );

  // Next state. In busy states: abort > both-done > stray-done > normal > timeout.
  // Timeout only fires when no done flag is present, so it never competes with
  // the done-driven transitions.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_start) begin
          state_d = StUpdate;
        end
      end

      StUpdate, StWrite, StCheck: begin
        if (bus.in_abort) begin
          state_d = StIdle;
        end else if (upd_done && wr_done) begin
          state_d    = StError;
          err_code_d = ERR_BOTH;
        end else begin
          unique case (state_q)
            StUpdate: begin
              if (wr_done) begin
                state_d    = StError;
                err_code_d = ERR_STRAY;
              end else if (upd_done) begin
                state_d = StWrite;
              end else if (wdg_expired) begin
                state_d    = StError;
                err_code_d = ERR_TMO;
              end
            end
            StWrite: begin
              if (upd_done) begin
                state_d    = StError;
                err_code_d = ERR_STRAY;
              end else if (wr_done) begin
                state_d = StCheck;
              end else if (wdg_expired) begin
                state_d    = StError;
                err_code_d = ERR_TMO;
              end
            end
            default: begin
              // StCheck: one cycle, any done flag here is left over from a source
              // that did not drop it.
              if (upd_done || wr_done) begin
                state_d    = StError;
                err_code_d = ERR_STRAY;
              end else if ((iter_q == ITER_W'(NUM_ITER)) || bus.in_converged) begin
                state_d = StDone;
              end else begin
                state_d = StUpdate;
              end
            end
          endcase
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      StError: begin
        if (bus.in_clearErr) begin
          state_d    = StIdle;
          err_code_d = ERR_NONE;
        end
      end

      default: begin
        state_d    = StIdle;
        err_code_d = ERR_NONE;
      end
    endcase
  end

  // Iteration count: cleared by a start, bumped on each completed write phase,
  // otherwise held (including across abort and DONE).
  always_comb begin
    iter_d = iter_q;
    if ((state_q == StIdle) && bus.in_start) begin
      iter_d = '0;
    end else if ((state_q == StWrite) && (state_d == StCheck)) begin
      iter_d = iter_q + ITER_W'(1);
    end
  end

  // Outputs are decoded from the next state so that they are registered yet
  // line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      iter_q     <= '0;
      err_code_q <= ERR_NONE;
      upd_en_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      err_code_q <= err_code_d;
      upd_en_q   <= (state_d == StUpdate);
      wr_en_q    <= (state_d == StWrite);
      busy_q     <= is_busy(state_d);
      all_done_q <= (state_d == StDone);
      error_q    <= (state_d == StError);
    end
  end

  assign bus.op_updateYmoduleEnable = upd_en_q;
  assign bus.op_writeYvalEnable     = wr_en_q;
  assign bus.op_busy                = busy_q;
  assign bus.op_allDone             = all_done_q;
  assign bus.op_iterCount           = iter_q;
  assign bus.op_error               = error_q;
  assign bus.op_errorCode           = err_code_q;

endmodule

// File: tb/tb_y_update_sequencer.sv
module tb_y_update_sequencer;
  import y_update_pkg::*;

  localparam int unsigned NUM_ITER    = 3;
  localparam int unsigned ITER_W      = 8;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned TMO_W       = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int checks   = 0;
  int failures = 0;

  // Scoreboards: expected iterCount at each allDone, expected error codes.
  int         exp_iter_q[$];
  logic [1:0] exp_err_q[$];

  int done_pulses  = 0;
  bit overlap_seen = 1'b0;

  y_update_sequencer_if #(.ITER_W(ITER_W)) bus ();

  y_update_sequencer #(
    .NUM_ITER    (NUM_ITER),
    .ITER_W      (ITER_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMO_W       (TMO_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  // Monitor on the falling edge: enable overlap and allDone pulses vs scoreboard.
  initial begin
    int e;
    forever begin
      @(negedge clock);
      if (bus.op_updateYmoduleEnable && bus.op_writeYvalEnable) overlap_seen = 1'b1;
      if (bus.op_allDone === 1'b1) begin
        done_pulses++;
        checks++;
        if (exp_iter_q.size() == 0) begin
          failures++;
          $display("FAIL alldone_unexpected iterCount=%0d required=no_pulse", bus.op_iterCount);
        end else begin
          e = exp_iter_q.pop_front();
          if (bus.op_iterCount !== ITER_W'(e)) begin
            failures++;
            $display("FAIL alldone_iter got=%0d exp=%0d", bus.op_iterCount, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return bus.op_updateYmoduleEnable;
      1:       return bus.op_writeYvalEnable;
      default: return bus.op_error;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int bound);
    int waited = 0;
    while (sig(which) !== 1'b1) begin
      if (waited >= bound) begin
        checks++;
        failures++;
        $display("FAIL wait_sig%0d got=timeout exp=high_within_%0d", which, bound);
        return;
      end
      cyc(1);
      waited++;
    end
  endtask

  task automatic pulse_upd();
    bus.in_updateYCtrlPathDoneFlag = 1'b1;
    cyc(1);
    bus.in_updateYCtrlPathDoneFlag = 1'b0;
  endtask

  task automatic pulse_wr();
    bus.in_updateYwriteDoneFlag = 1'b1;
    cyc(1);
    bus.in_updateYwriteDoneFlag = 1'b0;
  endtask

  task automatic do_start();
    bus.in_start = 1'b1;
    cyc(1);
    bus.in_start = 1'b0;
  endtask

  task automatic clear_err();
    bus.in_clearErr = 1'b1;
    cyc(1);
    bus.in_clearErr = 1'b0;
    checks++;
    if (bus.op_error !== 1'b0 || bus.op_errorCode !== ERR_NONE || bus.op_busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_err got=err%b code%b busy%b exp=0 00 0",
               bus.op_error, bus.op_errorCode, bus.op_busy);
    end
  endtask

  // Error expected right now: pop the scoreboard entry and compare.
  task automatic check_err(input string name);
    logic [1:0] e;
    checks++;
    if (exp_err_q.size() == 0) begin
      failures++;
      $display("FAIL %s got=no_expectation exp=queued_code", name);
      return;
    end
    e = exp_err_q.pop_front();
    if (bus.op_error !== 1'b1 || bus.op_errorCode !== e || bus.op_updateYmoduleEnable !== 1'b0 ||
        bus.op_writeYvalEnable !== 1'b0 || bus.op_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s got=err%b code%b en%b%b busy%b exp=err1 code%b en00 busy0", name,
               bus.op_error, bus.op_errorCode, bus.op_updateYmoduleEnable,
               bus.op_writeYvalEnable, bus.op_busy, e);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    checks++;
    if (bus.op_updateYmoduleEnable !== 1'b0 || bus.op_writeYvalEnable !== 1'b0 ||
        bus.op_busy !== 1'b0 || bus.op_allDone !== 1'b0 || bus.op_iterCount !== '0 ||
        bus.op_error !== 1'b0 || bus.op_errorCode !== 2'b00) begin
      failures++;
      $display("FAIL reset_values got=en%b%b busy%b done%b it%0d err%b code%b exp=all_zero",
               bus.op_updateYmoduleEnable, bus.op_writeYvalEnable, bus.op_busy,
               bus.op_allDone, bus.op_iterCount, bus.op_error, bus.op_errorCode);
    end
    bus.in_start = 1'b1;
    cyc(2);
    checks++;
    if (bus.op_busy !== 1'b0 || bus.op_updateYmoduleEnable !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold got=busy%b en%b exp=0 0", bus.op_busy, bus.op_updateYmoduleEnable);
    end
    bus.in_start = 1'b0;
    reset = 1'b1;
    cyc(1);
    // Done flags while idle are ignored.
    pulse_upd();
    pulse_wr();
    checks++;
    if (bus.op_error !== 1'b0 || bus.op_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_done_ignored got=err%b busy%b exp=0 0", bus.op_error, bus.op_busy);
    end
  endtask

  // Full run; conv_at>0 raises in_converged in the CHECK of that iteration.
  task automatic do_run(input int conv_at, input string name);
    int exp_n = (conv_at > 0) ? conv_at : int'(NUM_ITER);
    int d0 = done_pulses;
    exp_iter_q.push_back(exp_n);
    overlap_seen = 1'b0;
    do_start();
    checks++;
    if (bus.op_updateYmoduleEnable !== 1'b1 || bus.op_busy !== 1'b1 || bus.op_iterCount !== '0) begin
      failures++;
      $display("FAIL %s_start got=en%b busy%b it%0d exp=1 1 0", name,
               bus.op_updateYmoduleEnable, bus.op_busy, bus.op_iterCount);
    end
    for (int i = 1; i <= exp_n; i++) begin
      wait_sig(0, 20);
      cyc(3);
      pulse_upd();
      checks++;
      if (bus.op_writeYvalEnable !== 1'b1 || bus.op_updateYmoduleEnable !== 1'b0) begin
        failures++;
        $display("FAIL %s_handover%0d got=upd%b wr%b exp=upd0 wr1", name, i,
                 bus.op_updateYmoduleEnable, bus.op_writeYvalEnable);
      end
      cyc(3);
      pulse_wr();
      checks++;
      if (bus.op_iterCount !== ITER_W'(i) || bus.op_writeYvalEnable !== 1'b0 ||
          bus.op_updateYmoduleEnable !== 1'b0 || bus.op_busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_check%0d got=it%0d en%b%b busy%b exp=it%0d en00 busy1", name, i,
                 bus.op_iterCount, bus.op_updateYmoduleEnable, bus.op_writeYvalEnable,
                 bus.op_busy, i);
      end
      if (i == conv_at) begin
        bus.in_converged = 1'b1;
        cyc(1);
        bus.in_converged = 1'b0;
      end
    end
    cyc(4);
    checks++;
    if (done_pulses - d0 != 1 || overlap_seen || bus.op_busy !== 1'b0 ||
        bus.op_iterCount !== ITER_W'(exp_n) || exp_iter_q.size() != 0) begin
      failures++;
      $display("FAIL %s_end got=pulses%0d overlap%0d busy%b it%0d pending%0d exp=1 0 0 %0d 0",
               name, done_pulses - d0, overlap_seen, bus.op_busy, bus.op_iterCount,
               exp_iter_q.size(), exp_n);
    end
  endtask

  task automatic test_normal_run();
    do_run(0, "normal");
  endtask

  task automatic test_converge();
    do_run(2, "converge");
  endtask

  task automatic test_both_done();
    do_start();
    wait_sig(0, 20);
    exp_err_q.push_back(ERR_BOTH);
    bus.in_updateYCtrlPathDoneFlag = 1'b1;
    bus.in_updateYwriteDoneFlag    = 1'b1;
    cyc(1);
    bus.in_updateYCtrlPathDoneFlag = 1'b0;
    bus.in_updateYwriteDoneFlag    = 1'b0;
    check_err("both_done");
    // Start is ignored while in error.
    do_start();
    cyc(1);
    checks++;
    if (bus.op_error !== 1'b1 || bus.op_errorCode !== ERR_BOTH || bus.op_busy !== 1'b0) begin
      failures++;
      $display("FAIL err_sticky got=err%b code%b busy%b exp=1 10 0",
               bus.op_error, bus.op_errorCode, bus.op_busy);
    end
    clear_err();
  endtask

  task automatic test_stray_done();
    do_start();
    wait_sig(0, 20);
    exp_err_q.push_back(ERR_STRAY);
    pulse_wr();
    check_err("stray_done");
    clear_err();
  endtask

  task automatic test_timeout();
    do_start();
    wait_sig(0, 20);
    cyc(3);
    pulse_upd();
    // Write enable rose on the edge just passed.
    exp_err_q.push_back(ERR_TMO);
    cyc(TIMEOUT_CYC - 1);
    checks++;
    if (bus.op_error !== 1'b0 || bus.op_writeYvalEnable !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early got=err%b wr%b exp=err0 wr1", bus.op_error,
               bus.op_writeYvalEnable);
    end
    cyc(1);
    check_err("timeout");
    clear_err();
  endtask

  task automatic test_abort();
    int d0 = done_pulses;
    do_start();
    wait_sig(0, 20);
    cyc(3);
    pulse_upd();
    cyc(3);
    pulse_wr();
    wait_sig(0, 20);
    cyc(3);
    pulse_upd();
    bus.in_abort = 1'b1;
    cyc(1);
    bus.in_abort = 1'b0;
    checks++;
    if (bus.op_busy !== 1'b0 || bus.op_writeYvalEnable !== 1'b0 ||
        bus.op_updateYmoduleEnable !== 1'b0 || bus.op_iterCount !== ITER_W'(1)) begin
      failures++;
      $display("FAIL abort got=busy%b en%b%b it%0d exp=busy0 en00 it1", bus.op_busy,
               bus.op_updateYmoduleEnable, bus.op_writeYvalEnable, bus.op_iterCount);
    end
    cyc(3);
    checks++;
    if (done_pulses != d0 || bus.op_error !== 1'b0) begin
      failures++;
      $display("FAIL abort_nodone got=pulses%0d err%b exp=0 0", done_pulses - d0, bus.op_error);
    end
  endtask

  task automatic test_reset_midrun();
    int d0 = done_pulses;
    do_start();
    wait_sig(0, 20);
    cyc(3);
    pulse_upd();
    cyc(3);
    pulse_wr();
    wait_sig(0, 20);
    cyc(1);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.op_updateYmoduleEnable !== 1'b0 || bus.op_writeYvalEnable !== 1'b0 ||
        bus.op_busy !== 1'b0 || bus.op_iterCount !== '0 || bus.op_error !== 1'b0 ||
        bus.op_allDone !== 1'b0) begin
      failures++;
      $display("FAIL reset_midrun got=en%b%b busy%b it%0d err%b done%b exp=all_zero",
               bus.op_updateYmoduleEnable, bus.op_writeYvalEnable, bus.op_busy,
               bus.op_iterCount, bus.op_error, bus.op_allDone);
    end
    cyc(1);
    reset = 1'b1;
    cyc(3);
    checks++;
    if (done_pulses != d0 || bus.op_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_nodone got=pulses%0d busy%b exp=0 0", done_pulses - d0, bus.op_busy);
    end
  endtask

  initial begin
    bus.in_start                   = 1'b0;
    bus.in_abort                   = 1'b0;
    bus.in_clearErr                = 1'b0;
    bus.in_converged               = 1'b0;
    bus.in_updateYCtrlPathDoneFlag = 1'b0;
    bus.in_updateYwriteDoneFlag    = 1'b0;

    test_reset();
    test_normal_run();
    test_converge();
    test_both_done();
    test_stray_done();
    test_timeout();
    test_abort();
    test_reset_midrun();
    test_normal_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
